// File: rtl/parity_game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parity_game_pkg                                                      |
// | Shared state encoding and digit constants for the odd/even game.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package parity_game_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CAPTURE = 3'd1;
    localparam state_t ST_GUESS   = 3'd2;
    localparam state_t ST_RESULT  = 3'd3;
    localparam state_t ST_OVER    = 3'd4;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] DIGIT_MAX   = 4'd9;

endpackage
`default_nettype wire

// File: rtl/key_fall_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_fall_detect                                                      |
// | Synchronous falling-edge detector for an active-low debounced key.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module key_fall_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_fall
);

    logic r_prev;
    logic r_armed;

    // r_armed stays low until the key has been seen released, so a key held
    // down across reset cannot masquerade as a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 1'b1;
            r_armed <= i_key_n;
        end else begin
            r_prev  <= i_key_n;
            r_armed <= r_armed | i_key_n;
        end
    end

    assign o_fall = r_prev & ~i_key_n & r_armed;

endmodule
`default_nettype wire

// File: rtl/parity_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parity_game_ctrl                                                     |
// | Round controller: captures the drawn digit, judges odd/even guesses, |
// | keeps score over a fixed number of rounds and drives the display.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module parity_game_ctrl #(
    parameter int ROUNDS      = 5,
    parameter int SHOW_CYCLES = 50_000_000,
    parameter int SCORE_W     = 3
) (
    input  logic               clk,
    input  logic               r,
    input  logic               start_n,
    input  logic               guess_odd_n,
    input  logic               guess_even_n,
    input  logic [3:0]         num,
    input  logic               odd,
    output logic [3:0]         disp_num,
    output logic               win,
    output logic               lose,
    output logic               err,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] round,
    output logic               game_over,
    output logic               busy
);

    import parity_game_pkg::*;

    localparam int TIMER_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] c_show_last = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [SCORE_W-1:0] c_rounds    = SCORE_W'(ROUNDS);

    logic w_start;
    logic w_godd;
    logic w_geven;

    key_fall_detect u_key_start (
        .clk     (clk),
        .rst     (r),
        .i_key_n (start_n),
        .o_fall  (w_start)
    );

    key_fall_detect u_key_odd (
        .clk     (clk),
        .rst     (r),
        .i_key_n (guess_odd_n),
        .o_fall  (w_godd)
    );

    key_fall_detect u_key_even (
        .clk     (clk),
        .rst     (r),
        .i_key_n (guess_even_n),
        .o_fall  (w_geven)
    );

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TIMER_W-1:0]   r_timer;
    logic [3:0]           r_digit;
    logic                 r_odd;
    logic [3:0]           r_disp;
    logic                 r_win;
    logic                 r_lose;
    logic                 r_err;
    logic [SCORE_W-1:0]   r_score;
    logic [SCORE_W-1:0]   r_round;
    logic                 r_over;
    logic                 r_busy;

    logic                 w_one_guess;
    logic                 w_guess_ok;
    logic                 w_show_done;
    logic [SCORE_W-1:0]   w_round_inc;
    logic                 w_last_round;
    logic                 w_bad_digit;

    // Simultaneous odd and even presses are ambiguous and are dropped.
    assign w_one_guess  = w_godd ^ w_geven;
    assign w_guess_ok   = (w_godd == r_odd);
    assign w_show_done  = (r_timer == c_show_last);
    assign w_round_inc  = r_round + SCORE_W'(1);
    assign w_last_round = (w_round_inc == c_rounds);
    assign w_bad_digit  = (num > DIGIT_MAX);

    always_ff @(posedge clk) begin
        if (r) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_start) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = w_bad_digit ? ST_IDLE : ST_GUESS;
            ST_GUESS:   if (w_one_guess) w_state_nxt = ST_RESULT;
            ST_RESULT:  if (w_show_done) w_state_nxt = w_last_round ? ST_OVER : ST_IDLE;
            ST_OVER:    if (w_start) w_state_nxt = ST_CAPTURE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    logic [3:0]         w_disp_nxt;
    logic               w_win_nxt;
    logic               w_lose_nxt;
    logic               w_err_nxt;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [SCORE_W-1:0] w_round_nxt;
    logic               w_over_nxt;
    logic               w_busy_nxt;

    // Outputs are computed from the upcoming state and registered below.
    always_comb begin
        w_disp_nxt  = DIGIT_BLANK;
        w_win_nxt   = r_win;
        w_lose_nxt  = r_lose;
        w_err_nxt   = (r_state == ST_CAPTURE) && w_bad_digit;
        w_score_nxt = r_score;
        w_round_nxt = r_round;
        w_over_nxt  = (w_state_nxt == ST_OVER);
        w_busy_nxt  = (w_state_nxt == ST_CAPTURE) || (w_state_nxt == ST_GUESS) ||
                      (w_state_nxt == ST_RESULT);

        if ((w_state_nxt == ST_RESULT) || (w_state_nxt == ST_OVER)) begin
            w_disp_nxt = r_digit;
        end

        if ((r_state == ST_GUESS) && w_one_guess) begin
            w_win_nxt  = w_guess_ok;
            w_lose_nxt = !w_guess_ok;
            if (w_guess_ok) begin
                w_score_nxt = r_score + SCORE_W'(1);
            end
        end else if (w_state_nxt != ST_RESULT) begin
            w_win_nxt  = 1'b0;
            w_lose_nxt = 1'b0;
        end

        if ((r_state == ST_RESULT) && w_show_done) begin
            w_round_nxt = w_round_inc;
        end

        if ((r_state == ST_OVER) && w_start) begin
            w_score_nxt = '0;
            w_round_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            r_timer <= '0;
            r_digit <= DIGIT_BLANK;
            r_odd   <= 1'b0;
            r_disp  <= DIGIT_BLANK;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
            r_err   <= 1'b0;
            r_score <= '0;
            r_round <= '0;
            r_over  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_timer <= (r_state == ST_RESULT) ? r_timer + TIMER_W'(1) : '0;
            if (r_state == ST_CAPTURE) begin
                r_digit <= num;
                r_odd   <= odd;
            end
            r_disp  <= w_disp_nxt;
            r_win   <= w_win_nxt;
            r_lose  <= w_lose_nxt;
            r_err   <= w_err_nxt;
            r_score <= w_score_nxt;
            r_round <= w_round_nxt;
            r_over  <= w_over_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign disp_num  = r_disp;
    assign win       = r_win;
    assign lose      = r_lose;
    assign err       = r_err;
    assign score     = r_score;
    assign round     = r_round;
    assign game_over = r_over;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_parity_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_parity_game_ctrl                                                  |
// | Self-checking bench: round table plus error, double-key and reset.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_parity_game_ctrl;

    import parity_game_pkg::*;

    localparam int ROUNDS      = 2;
    localparam int SHOW_CYCLES = 4;
    localparam int SCORE_W     = 3;

    logic               clk = 1'b0;
    logic               r;
    logic               start_n;
    logic               guess_odd_n;
    logic               guess_even_n;
    logic [3:0]         num;
    logic               odd;
    logic [3:0]         disp_num;
    logic               win;
    logic               lose;
    logic               err;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] round;
    logic               game_over;
    logic               busy;

    always #5 clk = ~clk;

    parity_game_ctrl #(
        .ROUNDS      (ROUNDS),
        .SHOW_CYCLES (SHOW_CYCLES),
        .SCORE_W     (SCORE_W)
    ) dut (
        .clk          (clk),
        .r            (r),
        .start_n      (start_n),
        .guess_odd_n  (guess_odd_n),
        .guess_even_n (guess_even_n),
        .num          (num),
        .odd          (odd),
        .disp_num     (disp_num),
        .win          (win),
        .lose         (lose),
        .err          (err),
        .score        (score),
        .round        (round),
        .game_over    (game_over),
        .busy         (busy)
    );

    typedef struct {
        logic [3:0]         num;
        logic               odd;
        logic               guess_odd;
        logic               exp_win;
        logic [SCORE_W-1:0] exp_score;
        logic [SCORE_W-1:0] exp_round;
        logic               exp_over;
    } vec_t;

    typedef struct {
        logic               win;
        logic               lose;
        logic [SCORE_W-1:0] score;
        logic [3:0]         disp;
    } sb_t;

    int  n_checks = 0;
    int  n_errors = 0;
    sb_t sb_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard empty actual=none required=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_win"},   win,      e.win);
            chk({tag, "_lose"},  lose,     e.lose);
            chk({tag, "_score"}, score,    e.score);
            chk({tag, "_disp"},  disp_num, e.disp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, dut.r_state, ST_IDLE);
        chk({tag, "_score"}, score,       0);
        chk({tag, "_round"}, round,       0);
        chk({tag, "_win"},   win,         0);
        chk({tag, "_lose"},  lose,        0);
        chk({tag, "_err"},   err,         0);
        chk({tag, "_over"},  game_over,   0);
        chk({tag, "_busy"},  busy,        0);
        chk({tag, "_disp"},  disp_num,    4'hF);
    endtask

    // Press start and walk through CAPTURE into GUESS.
    task automatic start_round(input logic [3:0] n, input logic o,
                               input logic [SCORE_W-1:0] exp_score,
                               input logic [SCORE_W-1:0] exp_round);
        num     = n;
        odd     = o;
        start_n = 1'b0;
        tick();
        chk("capture_state", dut.r_state, ST_CAPTURE);
        chk("capture_busy",  busy,        1);
        chk("capture_disp",  disp_num,    4'hF);
        chk("capture_score", score,       exp_score);
        chk("capture_round", round,       exp_round);
        chk("capture_over",  game_over,   0);
        start_n = 1'b1;
        tick();
        chk("guess_state", dut.r_state, ST_GUESS);
        chk("guess_busy",  busy,        1);
        chk("guess_err",   err,         0);
        chk("guess_disp",  disp_num,    4'hF);
    endtask

    // Press one guess key, check RESULT entry and the round close-out.
    task automatic guess_and_show(input logic g_odd, input sb_t e,
                                  input logic [SCORE_W-1:0] exp_round,
                                  input logic exp_over, input logic [3:0] digit);
        if (g_odd) guess_odd_n = 1'b0;
        else       guess_even_n = 1'b0;
        sb_q.push_back(e);
        tick();
        guess_odd_n  = 1'b1;
        guess_even_n = 1'b1;
        chk("result_state", dut.r_state, ST_RESULT);
        chk("result_busy",  busy,        1);
        sb_check("result");
        repeat (SHOW_CYCLES - 1) tick();
        chk("show_state", dut.r_state, ST_RESULT);
        chk("show_round", round,       exp_round - 1'b1);
        chk("show_win",   win,         e.win);
        tick();
        chk("end_round", round,       exp_round);
        chk("end_state", dut.r_state, exp_over ? ST_OVER : ST_IDLE);
        chk("end_over",  game_over,   exp_over);
        chk("end_win",   win,         0);
        chk("end_lose",  lose,        0);
        chk("end_busy",  busy,        0);
        chk("end_disp",  disp_num,    exp_over ? digit : 4'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t               vecs[4];
        sb_t                e;
        logic [SCORE_W-1:0] pre_score;
        logic [SCORE_W-1:0] pre_round;

        vecs[0] = '{4'd7, 1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 1'b0};
        vecs[1] = '{4'd4, 1'b0, 1'b1, 1'b0, 3'd1, 3'd2, 1'b1};
        vecs[2] = '{4'd2, 1'b0, 1'b0, 1'b1, 3'd1, 3'd1, 1'b0};
        vecs[3] = '{4'd9, 1'b1, 1'b1, 1'b1, 3'd2, 3'd2, 1'b1};

        r            = 1'b1;
        start_n      = 1'b1;
        guess_odd_n  = 1'b1;
        guess_even_n = 1'b1;
        num          = 4'hF;
        odd          = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset");
        r = 1'b0;
        tick();
        check_reset_outputs("post_reset");

        // Table-driven game: win, lose (game over), restart + win, win (game over).
        pre_score = '0;
        pre_round = '0;
        for (int i = 0; i < 4; i++) begin
            start_round(vecs[i].num, vecs[i].odd, pre_score, pre_round);
            e.win   = vecs[i].exp_win;
            e.lose  = !vecs[i].exp_win;
            e.score = vecs[i].exp_score;
            e.disp  = vecs[i].num;
            guess_and_show(vecs[i].guess_odd, e, vecs[i].exp_round,
                           vecs[i].exp_over, vecs[i].num);
            chk("table_score", score, vecs[i].exp_score);
            pre_score = vecs[i].exp_over ? '0 : vecs[i].exp_score;
            pre_round = vecs[i].exp_over ? '0 : vecs[i].exp_round;
        end

        // Invalid digit drawn on the restart press out of OVER.
        num     = 4'hF;
        odd     = 1'b0;
        start_n = 1'b0;
        tick();
        chk("bad_capture_state", dut.r_state, ST_CAPTURE);
        chk("bad_capture_score", score,       0);
        chk("bad_capture_round", round,       0);
        start_n = 1'b1;
        tick();
        chk("bad_err",   err,         1);
        chk("bad_state", dut.r_state, ST_IDLE);
        chk("bad_round", round,       0);
        chk("bad_disp",  disp_num,    4'hF);
        chk("bad_busy",  busy,        0);
        tick();
        chk("bad_err_pulse", err, 0);

        // Both guess keys together, then a start press: both ignored in GUESS.
        start_round(4'd3, 1'b1, 3'd0, 3'd0);
        guess_odd_n  = 1'b0;
        guess_even_n = 1'b0;
        tick();
        chk("dual_state", dut.r_state, ST_GUESS);
        chk("dual_win",   win,         0);
        chk("dual_lose",  lose,        0);
        chk("dual_disp",  disp_num,    4'hF);
        guess_odd_n  = 1'b1;
        guess_even_n = 1'b1;
        tick();
        start_n = 1'b0;
        tick();
        chk("dual_start_state", dut.r_state, ST_GUESS);
        chk("dual_start_busy",  busy,        1);
        chk("dual_start_score", score,       0);
        start_n = 1'b1;
        tick();
        e.win   = 1'b0;
        e.lose  = 1'b1;
        e.score = 3'd0;
        e.disp  = 4'd3;
        guess_and_show(1'b0, e, 3'd1, 1'b0, 4'd3);

        // Reset in the middle of RESULT with every key held down.
        start_round(4'd6, 1'b0, 3'd0, 3'd1);
        guess_even_n = 1'b0;
        sb_q.push_back('{1'b1, 1'b0, 3'd1, 4'd6});
        tick();
        guess_even_n = 1'b1;
        sb_check("pre_reset");
        tick();
        r            = 1'b1;
        start_n      = 1'b0;
        guess_odd_n  = 1'b0;
        guess_even_n = 1'b0;
        tick();
        check_reset_outputs("mid_reset");
        r = 1'b0;
        repeat (3) tick();
        chk("held_state", dut.r_state, ST_IDLE);
        chk("held_busy",  busy,        0);
        start_n      = 1'b1;
        guess_odd_n  = 1'b1;
        guess_even_n = 1'b1;
        tick();
        chk("release_state", dut.r_state, ST_IDLE);
        start_round(4'd5, 1'b1, 3'd0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
